// File: rtl/seq_stage_controller_if.sv
// Handshake bundle between the SEQ stage sequencer and the datapath.
// The master side is the sequencer; the slave side is the datapath or a bench.
interface seq_stage_controller_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [3:0]       icode;
    logic             imem_error;
    logic             dmem_error;
    logic [2:0]       cc_in;

    logic             fetch_en;
    logic             decode_en;
    logic             execute_en;
    logic             memory_en;
    logic             writeback_en;
    logic             pc_en;
    logic [3:0]       icode_q;
    logic [2:0]       cc_q;
    logic [2:0]       stat;
    logic             running;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, icode, imem_error, dmem_error, cc_in,
        output fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
               icode_q, cc_q, stat, running, retired
    );

    modport slave (
        output start, icode, imem_error, dmem_error, cc_in,
        input  fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en,
               icode_q, cc_q, stat, running, retired
    );
endinterface

// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ Y86-64 sequencer: one stage enable per clock, owns the
// condition codes, processor status and the retired-instruction counter.
module seq_stage_controller #(
    parameter logic [2:0] CC_RESET = 3'b001,
    parameter int         CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    seq_stage_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPD,
        S_HALTED
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [3:0] ICODE_MAX  = 4'hB;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [5:0]       en_q, en_d;
    logic             running_q, running_d;
    logic [3:0]       icode_q, icode_d;
    logic [2:0]       cc_q, cc_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        icode_d   = icode_q;
        cc_d      = cc_q;
        stat_d    = stat_q;
        retired_d = retired_q;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    stat_d  = STAT_AOK;
                end
            end
            S_FETCH: begin
                icode_d = bus.icode;
                // Address error outranks an invalid opcode, which outranks halt.
                if (bus.imem_error) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else if (bus.icode > ICODE_MAX) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_INS;
                end else if (bus.icode == ICODE_HALT) begin
                    state_d   = S_HALTED;
                    stat_d    = STAT_HLT;
                    retired_d = retired_q + CNT_ONE;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_MEMORY;
                if (icode_q == ICODE_OPQ) begin
                    cc_d = bus.cc_in;
                end
            end
            S_MEMORY: begin
                if (bus.dmem_error) begin
                    state_d = S_HALTED;
                    stat_d  = STAT_ADR;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: state_d = S_PCUPD;
            S_PCUPD: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_ONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Enables are decoded from the next state so they come out of flops.
        en_d = 6'b000000;
        case (state_d)
            S_FETCH:     en_d = 6'b000001;
            S_DECODE:    en_d = 6'b000010;
            S_EXECUTE:   en_d = 6'b000100;
            S_MEMORY:    en_d = 6'b001000;
            S_WRITEBACK: en_d = 6'b010000;
            S_PCUPD:     en_d = 6'b100000;
            default:     en_d = 6'b000000;
        endcase
        running_d = |en_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            en_q      <= 6'b000000;
            running_q <= 1'b0;
            icode_q   <= 4'h0;
            cc_q      <= CC_RESET;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            running_q <= running_d;
            icode_q   <= icode_d;
            cc_q      <= cc_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    assign bus.fetch_en     = en_q[0];
    assign bus.decode_en    = en_q[1];
    assign bus.execute_en   = en_q[2];
    assign bus.memory_en    = en_q[3];
    assign bus.writeback_en = en_q[4];
    assign bus.pc_en        = en_q[5];
    assign bus.running      = running_q;
    assign bus.icode_q      = icode_q;
    assign bus.cc_q         = cc_q;
    assign bus.stat         = stat_q;
    assign bus.retired      = retired_q;
endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller: table vectors, random instruction stream
// against an instruction-level model, reset abort and 4-bit counter wrap.
module tb_seq_stage_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_stage_controller_if #(.CNT_W(32)) bus ();
    seq_stage_controller_if #(.CNT_W(4))  bus4 ();

    seq_stage_controller #(.CC_RESET(3'b001), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    seq_stage_controller #(.CC_RESET(3'b001), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.master)
    );

    assign bus4.start      = bus.start;
    assign bus4.icode      = bus.icode;
    assign bus4.imem_error = bus.imem_error;
    assign bus4.dmem_error = bus.dmem_error;
    assign bus4.cc_in      = bus.cc_in;

    wire [5:0] en = {bus.pc_en, bus.writeback_en, bus.memory_en,
                     bus.execute_en, bus.decode_en, bus.fetch_en};

    int total = 0;
    int bad   = 0;

    // Instruction-level reference state
    logic [2:0]  mcc;
    logic [2:0]  mstat;
    logic [3:0]  micode;
    int unsigned mret;
    bit          halted;

    typedef struct {
        logic [3:0] ic;
        bit         im;
        bit         dm;
        logic [2:0] ccin;
        int         cycles;
        logic [2:0] st;
        string      tag;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outcome of one instruction from the architectural rules.
    function automatic void outcome(input logic [3:0] ic, input bit im, input bit dm,
                                    output int n, output logic [2:0] st);
        if (im)              begin n = 1; st = 3'd3; end
        else if (ic > 4'hB)  begin n = 1; st = 3'd4; end
        else if (ic == 4'h0) begin n = 1; st = 3'd2; end
        else if (dm)         begin n = 4; st = 3'd3; end
        else                 begin n = 6; st = 3'd1; end
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_en"},      32'(en), 32'd0);
        chk({tag, "_running"}, 32'(bus.running), 32'd0);
        chk({tag, "_cc"},      32'(bus.cc_q), 32'd1);
        chk({tag, "_stat"},    32'(bus.stat), 32'd1);
        chk({tag, "_retired"}, bus.retired, 32'd0);
        chk({tag, "_ret4"},    32'(bus4.retired), 32'd0);
        chk({tag, "_icode_q"}, 32'(bus.icode_q), 32'd0);
    endtask

    task automatic model_reset();
        mcc    = 3'b001;
        mstat  = 3'd1;
        micode = 4'h0;
        mret   = 0;
        halted = 1'b1;
    endtask

    task automatic check_parked(input string tag);
        chk({tag, "_idle_en"},      32'(en), 32'd0);
        chk({tag, "_idle_running"}, 32'(bus.running), 32'd0);
        chk({tag, "_idle_stat"},    32'(bus.stat), 32'(mstat));
        chk({tag, "_idle_cc"},      32'(bus.cc_q), 32'(mcc));
        chk({tag, "_idle_retired"}, bus.retired, mret);
        chk({tag, "_idle_ret4"},    32'(bus4.retired), 32'(mret & 32'hF));
        chk({tag, "_idle_icode_q"}, 32'(bus.icode_q), 32'(micode));
    endtask

    // Runs one instruction; resumes first if parked in IDLE/HALTED.
    task automatic do_instr(input logic [3:0] ic, input bit im, input bit dm,
                            input logic [2:0] ccin, input int n, input logic [2:0] st,
                            input int abort_at, input string tag);
        if (halted) begin
            @(negedge clk);
            check_parked(tag);
            bus.start      = 1'b1;
            bus.icode      = 4'($urandom_range(0, 15));
            bus.imem_error = 1'($urandom_range(0, 1));
            bus.dmem_error = 1'($urandom_range(0, 1));
            mstat  = 3'd1;
            halted = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({tag, "_en"},      32'(en), 32'(1 << k));
            chk({tag, "_running"}, 32'(bus.running), 32'd1);
            chk({tag, "_stat"},    32'(bus.stat), 32'd1);
            chk({tag, "_cc"},      32'(bus.cc_q), 32'(mcc));
            chk({tag, "_retired"}, bus.retired, mret);
            chk({tag, "_ret4"},    32'(bus4.retired), 32'(mret & 32'hF));
            if (k > 0) chk({tag, "_icode_q"}, 32'(bus.icode_q), 32'(ic));
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1 check_reset_vals({tag, "_abort"});
                model_reset();
                @(posedge clk);
                @(negedge clk);
                bus.start = 1'b0;
                reset     = 1'b0;
                return;
            end
            bus.start      = (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.icode      = (k == 0) ? ic : 4'($urandom_range(0, 15));
            bus.imem_error = (k == 0) ? im : 1'($urandom_range(0, 1));
            bus.dmem_error = (k == 3) ? dm : 1'($urandom_range(0, 1));
            bus.cc_in      = (k == 2) ? ccin : 3'($urandom_range(0, 7));
            if (k == 0) micode = ic;
            if (k == 2 && ic == 4'h6) mcc = ccin;
        end
        if (st == 3'd2 || n == 6) mret++;
        if (n != 6) begin
            mstat  = st;
            halted = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'h6, 1'b0, 1'b0, 3'b010, 6, 3'd1, "opq"};
        vecs[1]  = '{4'h3, 1'b0, 1'b0, 3'b111, 6, 3'd1, "irmovq"};
        vecs[2]  = '{4'h1, 1'b0, 1'b0, 3'b101, 6, 3'd1, "nop"};
        vecs[3]  = '{4'h0, 1'b0, 1'b0, 3'b000, 1, 3'd2, "halt"};
        vecs[4]  = '{4'h6, 1'b0, 1'b0, 3'b100, 6, 3'd1, "opq2"};
        vecs[5]  = '{4'hC, 1'b0, 1'b0, 3'b011, 1, 3'd4, "ins"};
        vecs[6]  = '{4'hC, 1'b1, 1'b0, 3'b011, 1, 3'd3, "imem_adr"};
        vecs[7]  = '{4'h5, 1'b0, 1'b1, 3'b011, 4, 3'd3, "dmem_adr"};
        vecs[8]  = '{4'h6, 1'b0, 1'b1, 3'b110, 4, 3'd3, "opq_dmem"};
        vecs[9]  = '{4'hB, 1'b0, 1'b0, 3'b001, 6, 3'd1, "popq"};
        vecs[10] = '{4'h2, 1'b0, 1'b0, 3'b000, 6, 3'd1, "rrmovq"};
        vecs[11] = '{4'hF, 1'b0, 1'b0, 3'b000, 1, 3'd4, "ins_f"};

        bus.start      = 1'b0;
        bus.icode      = 4'h0;
        bus.imem_error = 1'b0;
        bus.dmem_error = 1'b0;
        bus.cc_in      = 3'b000;
        reset          = 1'b0;

        // Asynchronous reset between edges must take effect immediately.
        #2 reset = 1'b1;
        #1 check_reset_vals("reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // IDLE ignores errors and opcodes while start is low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_parked("idle_hold");
            bus.icode      = 4'($urandom_range(0, 15));
            bus.imem_error = 1'($urandom_range(0, 1));
            bus.dmem_error = 1'($urandom_range(0, 1));
        end

        foreach (vecs[i]) begin
            do_instr(vecs[i].ic, vecs[i].im, vecs[i].dm, vecs[i].ccin,
                     vecs[i].cycles, vecs[i].st, -1, vecs[i].tag);
        end

        for (int i = 0; i < 250; i++) begin
            logic [3:0] ic;
            bit         im, dm;
            int         n;
            logic [2:0] st;
            ic = ($urandom_range(0, 99) < 75) ? 4'($urandom_range(1, 11))
                                              : 4'($urandom_range(0, 15));
            im = ($urandom_range(0, 19) == 0);
            dm = ($urandom_range(0, 14) == 0);
            outcome(ic, im, dm, n, st);
            do_instr(ic, im, dm, 3'($urandom_range(0, 7)), n, st, -1, "rand");
        end

        // Reset during WRITEBACK aborts the instruction with no retire.
        do_instr(4'h6, 1'b0, 1'b0, 3'b110, 6, 3'd1, 4, "wb_reset");

        // Sixteen nops wrap the 4-bit counter back to zero.
        for (int i = 0; i < 16; i++) begin
            do_instr(4'h1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), 6, 3'd1, -1, "wrap");
        end
        @(negedge clk);
        chk("wrap_ret4",    32'(bus4.retired), 32'd0);
        chk("wrap_retired", bus.retired, 32'd16);
        chk("wrap_fetch",   32'(en), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
